serial_ripple_adder: RTL and testbench
======================================

# serial_ripple_adder

Bit-serial ripple-carry adder. It performs the inverse of the team's ripple borrow subtractor: given a difference, subtrahend and borrow, it reconstructs the minuend with the carry. It instantiates one full-adder cell and reuses it over WIDTH clock cycles, trading latency for area. A start/done handshake drives it from a controller, and the datapath sits beside the subtractor in the arithmetic test chain.

## Interface
Parameters:
- WIDTH, 8, operand and sum width in bits (must be ≥ 1)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; asynchronous, active-high
- start  input  1  request; sampled on a rising edge when not busy
- a  input  WIDTH  augend; captured when start is accepted
- b  input  WIDTH  addend; captured when start is accepted
- c  input  1  carry-in; captured when start is accepted
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; sum/carry valid from this cycle on
- sum  output  WIDTH  registered result; held until the next completion
- carry  output  1  registered carry-out; held with sum

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - On start=1, load the a/b shift registers, set carry_r=c and bit_cnt=0, then go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - Each cycle, the full adder takes (a_sh[0], b_sh[0], carry_r).
  - The sum bit shifts into the MSB of the sum shift register; a_sh and b_sh shift right; carry_r takes the carry-out; bit_cnt increments.
  - When bit_cnt = WIDTH-1 on an edge, that edge processes the last bit. On the same edge, copy the shift register plus the final carry into the sum/carry output registers and go to DONE.
- DONE:
  - done=1 for this cycle only.
  - If start=1, accept it exactly as in IDLE and go to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- busy=1 only in RUN. start is ignored while busy, and a/b/c changes during RUN have no effect.
- Arithmetic: {carry, sum} = a + b + c, computed modulo 2^(WIDTH+1). No overflow flag.
- sum/carry change only on the completion edge. They never show partial results.
- Reset values: state=IDLE; busy=0, done=0, sum=0, carry=0; shift registers and bit_cnt=0.
- Reset asserted mid-RUN aborts the operation. No done is produced, and outputs return to reset values.

## Timing
- Call the edge that accepts start E0. Bits 0..WIDTH-1 are processed on E1..E_WIDTH.
- Latency: done is high in the cycle after E_WIDTH, i.e. WIDTH+1 cycles after start is sampled. For WIDTH=8 that is 9 cycles.
- busy rises after E0 and falls after E_WIDTH.
- Throughput: one result per WIDTH+1 cycles, using back-to-back start in DONE.
- WIDTH=1: RUN lasts exactly one cycle.
- The critical path is one full-adder cell plus the shift mux, independent of WIDTH.

## Structure
- Shared package arith_pkg:
  - FSM state typedef (IDLE/RUN/DONE), 2-bit encoding
  - DEFAULT_WIDTH = 8
  - The package is shared with future serial subtractor/divider blocks.
- Sub-module Full_Adder (a, b, cin, sum, cout) is purely combinational and mirrors the existing Full_Subtractor cell. It is instantiated once.
- bit_cnt width is $clog2(WIDTH), with a minimum of 1.

## Test plan
- a=8'h5A, b=8'h3C, c=0, single start → done 9 cycles later, sum=8'h96, carry=0; busy high for exactly 8 cycles.
- a=8'hFF, b=8'h01, c=0 → sum=8'h00, carry=1. Then a=8'hFF, b=8'hFF, c=1 → sum=8'hFF, carry=1.
- start re-pulsed with a=8'h01, b=8'h01 during RUN of the 8'h5A+8'h3C operation → ignored; result stays 8'h96/0, and only one done pulse occurs.
- start held high in the DONE cycle with new operands 8'h10+8'h20 → second done exactly 9 cycles after the first, sum=8'h30. The first result stays visible until then.
- rst asserted asynchronously 4 cycles into RUN → busy, done, sum and carry go to 0 immediately. No done pulse follows, and a subsequent start completes normally.
- Exhaustive check with a WIDTH=4 instance: all a, b, c combinations → {carry, sum} == a+b+c.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic package: FSM state encoding and sizing helpers used by the
// serial arithmetic blocks (adder today, subtractor/divider later).
package arith_pkg;

  // Control states of the serial arithmetic engines.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Operand width used when an instance does not override it.
  localparam int DEFAULT_WIDTH = 8;

  // Width of a bit counter that walks 0..width-1; never narrower than 1 bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_ripple_adder_full_adder.sv
// One-bit full-adder cell, purely combinational. Companion to the
// Full_Subtractor cell used by the serial subtractor.
module Full_Adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_ripple_adder.sv
// Bit-serial ripple-carry adder. A single Full_Adder cell is reused over WIDTH
// cycles, LSB first, to produce {carry, sum} = a + b + c. A start/busy/done
// handshake lets a controller launch operations back to back.
// WIDTH must be at least 1.
module serial_ripple_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int                CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

  // FSM state
  state_e r_state;
  state_e w_state_nxt;

  // Datapath control decoded from the FSM
  logic w_load;   // capture operands and clear the bit counter
  logic w_step;   // process one bit through the full adder
  logic w_last;   // this step handles the MSB; publish the result

  // Working registers
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [CNT_W-1:0] r_bit_cnt;

  // Result registers; only written on the completion edge so partial sums
  // are never visible on the outputs.
  logic [WIDTH-1:0] r_sum;
  logic             r_carry_out;

  // Full-adder cell results and the next value of the sum shift register
  logic             w_fa_sum;
  logic             w_fa_cout;
  logic [WIDTH-1:0] w_sum_sh_nxt;

  // Single shared full-adder cell: the only arithmetic in the datapath, so the
  // critical path stays one cell plus the shift mux regardless of WIDTH.
  Full_Adder u_full_adder (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .cin  (r_carry),
    .sum  (w_fa_sum),
    .cout (w_fa_cout)
  );

  // New sum bit enters at the MSB; after WIDTH steps bit 0 sits at the LSB.
  if (WIDTH == 1) begin : g_sum_sh_one
    assign w_sum_sh_nxt = w_fa_sum;
  end else begin : g_sum_sh_multi
    assign w_sum_sh_nxt = {w_fa_sum, r_sum_sh[WIDTH-1:1]};
  end

  // State register.
  // NOTE: sequential blocks use non-blocking (<=) so every register samples
  // the pre-edge value of its neighbours; blocking here would race the shifts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath-control decode.
  // NOTE: every signal written here gets a default first; a path that skipped
  // one would make synthesis infer a latch to hold its old value.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end

      RUN: begin
        // start is deliberately not looked at here: requests while busy drop.
        w_step = 1'b1;
        if (r_bit_cnt == LAST_BIT) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end

      DONE: begin
        // Accepting here gives one result every WIDTH+1 cycles.
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture, bit-serial shifting and result publication.
  // NOTE: the shift registers and counter are reset too, even though a load
  // always precedes their use, so an aborted operation leaves no residue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_sum_sh    <= '0;
      r_carry     <= 1'b0;
      r_bit_cnt   <= '0;
      r_sum       <= '0;
      r_carry_out <= 1'b0;
    end else if (w_load) begin
      r_a_sh    <= a;
      r_b_sh    <= b;
      r_sum_sh  <= '0;
      r_carry   <= c;
      r_bit_cnt <= '0;
    end else if (w_step) begin
      r_a_sh    <= r_a_sh >> 1;
      r_b_sh    <= r_b_sh >> 1;
      r_sum_sh  <= w_sum_sh_nxt;
      r_carry   <= w_fa_cout;
      r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      if (w_last) begin
        r_sum       <= w_sum_sh_nxt;
        r_carry_out <= w_fa_cout;
      end
    end
  end

  // Handshake flags decode straight from the state register (glitch-free).
  assign busy  = (r_state == RUN);
  assign done  = (r_state == DONE);
  assign sum   = r_sum;
  assign carry = r_carry_out;

endmodule

// File: tb/tb_serial_ripple_adder.sv
// Directed bench for serial_ripple_adder: an 8-bit instance for the handshake
// scenarios and a 4-bit instance swept over every operand combination.
module tb_serial_ripple_adder;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // 8-bit instance
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       c8 = 1'b0;
  logic       busy8, done8, carry8;
  logic [7:0] sum8;

  // 4-bit instance
  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       c4 = 1'b0;
  logic       busy4, done4, carry4;
  logic [3:0] sum4;

  int assertions = 0;
  int failures   = 0;

  always #5 clk = ~clk;

  serial_ripple_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .c(c8),
    .busy(busy8), .done(done8), .sum(sum8), .carry(carry8)
  );

  serial_ripple_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .c(c4),
    .busy(busy4), .done(done4), .sum(sum4), .carry(carry4)
  );

  // Launch one 8-bit operation (start high for one cycle) and observe n_cycles
  // cycles, sampling on falling edges. Cycle k is the k-th falling edge after
  // start was raised; optionally re-pulses start with 1+1 at cycle repulse_at.
  task automatic launch8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                         input int repulse_at, input int n_cycles,
                         output int done_at, output int busy_cnt, output int done_cnt,
                         output logic [7:0] sum_at_done, output logic carry_at_done);
    done_at       = -1;
    busy_cnt      = 0;
    done_cnt      = 0;
    sum_at_done   = '0;
    carry_at_done = 1'b0;
    @(negedge clk);
    a8 = ta; b8 = tb; c8 = tc; start8 = 1'b1;
    for (int k = 1; k <= n_cycles; k++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (busy8) busy_cnt++;
      if (done8) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at       = k;
          sum_at_done   = sum8;
          carry_at_done = carry8;
        end
      end
      if (k == repulse_at) begin
        a8 = 8'h01; b8 = 8'h01; c8 = 1'b0; start8 = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    assertions++;
    if ({busy8, done8, carry8, sum8} !== 11'd0) begin
      failures++;
      $display("FAIL reset8: busy/done/carry/sum got %b/%b/%b/%h expected 0/0/0/00",
               busy8, done8, carry8, sum8);
    end
    assertions++;
    if ({busy4, done4, carry4, sum4} !== 7'd0) begin
      failures++;
      $display("FAIL reset4: busy/done/carry/sum got %b/%b/%b/%h expected 0/0/0/0",
               busy4, done4, carry4, sum4);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int d_at, b_cnt, d_cnt;
    logic [7:0] s;
    logic co;
    launch8(8'h5A, 8'h3C, 1'b0, 0, 14, d_at, b_cnt, d_cnt, s, co);
    assertions++;
    if (d_at !== 9) begin
      failures++;
      $display("FAIL basic_latency: done at cycle %0d expected 9", d_at);
    end
    assertions++;
    if (b_cnt !== 8) begin
      failures++;
      $display("FAIL basic_busy: busy for %0d cycles expected 8", b_cnt);
    end
    assertions++;
    if (d_cnt !== 1) begin
      failures++;
      $display("FAIL basic_done_pulses: %0d done cycles expected 1", d_cnt);
    end
    assertions++;
    if ({co, s} !== 9'h096) begin
      failures++;
      $display("FAIL basic_sum: carry/sum got %b/%h expected 0/96", co, s);
    end
  endtask

  task automatic test_carry();
    logic [7:0] va [3] = '{8'hFF, 8'hFF, 8'h00};
    logic [7:0] vb [3] = '{8'h01, 8'hFF, 8'h00};
    logic       vc [3] = '{1'b0, 1'b1, 1'b1};
    logic [8:0] ve [3] = '{9'h100, 9'h1FF, 9'h001};
    int d_at, b_cnt, d_cnt;
    logic [7:0] s;
    logic co;
    for (int i = 0; i < 3; i++) begin
      launch8(va[i], vb[i], vc[i], 0, 11, d_at, b_cnt, d_cnt, s, co);
      assertions++;
      if (d_at < 0 || {co, s} !== ve[i]) begin
        failures++;
        $display("FAIL carry_vec%0d: done_at %0d carry/sum got %b/%h expected %b/%h",
                 i, d_at, co, s, ve[i][8], ve[i][7:0]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int d_at, b_cnt, d_cnt;
    logic [7:0] s;
    logic co;
    launch8(8'h5A, 8'h3C, 1'b0, 3, 14, d_at, b_cnt, d_cnt, s, co);
    assertions++;
    if (d_cnt !== 1 || d_at !== 9) begin
      failures++;
      $display("FAIL ignore_done: %0d done cycles first at %0d expected 1 at 9", d_cnt, d_at);
    end
    assertions++;
    if ({co, s} !== 9'h096 || {carry8, sum8} !== 9'h096) begin
      failures++;
      $display("FAIL ignore_sum: carry/sum got %b/%h (now %b/%h) expected 0/96",
               co, s, carry8, sum8);
    end
  endtask

  task automatic test_back_to_back();
    int first_at = -1, second_at = -1, done_cnt = 0;
    bit stale_ok = 1'b1;
    logic [7:0] second_sum = '0;
    logic second_carry = 1'b0;
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h3C; c8 = 1'b0; start8 = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (done8) begin
        done_cnt++;
        if (first_at < 0) first_at = k;
        else if (second_at < 0) begin
          second_at    = k;
          second_sum   = sum8;
          second_carry = carry8;
        end
      end
      if (k == 9) begin
        assertions++;
        if (done8 !== 1'b1 || sum8 !== 8'h96) begin
          failures++;
          $display("FAIL b2b_first: done/sum got %b/%h expected 1/96", done8, sum8);
        end
        a8 = 8'h10; b8 = 8'h20; c8 = 1'b0; start8 = 1'b1;
      end
      if (k > 9 && k < 18 && {carry8, sum8} !== 9'h096) stale_ok = 1'b0;
    end
    assertions++;
    if (!stale_ok) begin
      failures++;
      $display("FAIL b2b_hold: first result changed before second done, got %b expected 1", stale_ok);
    end
    assertions++;
    if (first_at !== 9 || second_at !== 18 || done_cnt !== 2) begin
      failures++;
      $display("FAIL b2b_timing: done at %0d and %0d (%0d pulses) expected 9 and 18 (2)",
               first_at, second_at, done_cnt);
    end
    assertions++;
    if ({second_carry, second_sum} !== 9'h030) begin
      failures++;
      $display("FAIL b2b_sum: carry/sum got %b/%h expected 0/30", second_carry, second_sum);
    end
  endtask

  task automatic test_abort();
    int late_done = 0;
    int d_at, b_cnt, d_cnt;
    logic [7:0] s;
    logic co;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; start8 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start8 = 1'b0;
    end
    assertions++;
    if (busy8 !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre_busy: busy got %b expected 1", busy8);
    end
    rst = 1'b1;
    #1;
    assertions++;
    if ({busy8, done8, carry8, sum8} !== 11'd0) begin
      failures++;
      $display("FAIL abort_async: busy/done/carry/sum got %b/%b/%b/%h expected 0/0/0/00",
               busy8, done8, carry8, sum8);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8 || busy8) late_done++;
    end
    assertions++;
    if (late_done !== 0) begin
      failures++;
      $display("FAIL abort_quiet: %0d busy/done cycles after abort expected 0", late_done);
    end
    launch8(8'h5A, 8'h3C, 1'b0, 0, 11, d_at, b_cnt, d_cnt, s, co);
    assertions++;
    if (d_at !== 9 || {co, s} !== 9'h096) begin
      failures++;
      $display("FAIL abort_recover: done_at %0d carry/sum got %b/%h expected 9 0/96", d_at, co, s);
    end
  endtask

  task automatic test_exhaustive_w4();
    int got_at;
    logic [4:0] got, expv;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          @(negedge clk);
          a4 = 4'(ai); b4 = 4'(bi); c4 = ci[0]; start4 = 1'b1;
          got_at = -1;
          got    = '0;
          for (int k = 1; k <= 10 && got_at < 0; k++) begin
            @(negedge clk);
            start4 = 1'b0;
            if (done4) begin
              got_at = k;
              got    = {carry4, sum4};
            end
          end
          expv = 5'(ai + bi + ci);
          assertions++;
          if (got_at !== 5 || got !== expv) begin
            failures++;
            $display("FAIL w4_%0d_%0d_%0d: done_at %0d result got %h expected %h at 5",
                     ai, bi, ci, got_at, got, expv);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_ignore_start();
    test_back_to_back();
    test_abort();
    test_exhaustive_w4();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
